am_query_arbiter: RTL and testbench



---
 rtl/am_query_arbiter_pkg.sv | 26 ++
 rtl/am_rr_arbiter.sv | 70 +++++++
 rtl/am_query_arbiter.sv | 148 ++++++++++++++
 tb/tb_am_query_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_query_arbiter_pkg.sv
// Shared constants, FSM state encoding and helper function for the AM query arbiter.
// HvDimension, LabelWidth and DistanceWidth must match the associative_memory build.
package am_query_arbiter_pkg;

  localparam int unsigned HvDimension   = 64;
  localparam int unsigned LabelWidth    = 4;
  localparam int unsigned DistanceWidth = 8;

  typedef enum logic [1:0] {
    AmArbIdle       = 2'd0,
    AmArbIssue      = 2'd1,
    AmArbWaitResult = 2'd2,
    AmArbDeliver    = 2'd3
  } am_arb_state_e;

  // Minimum number of bits needed to index 'value' entries.
  function automatic int unsigned ceil_log2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/am_rr_arbiter.sv
// Combinational request arbiter: fixed priority (lowest index wins) by default,
// round-robin with a last-grant pointer when AM_ARB_ROUND_ROBIN_EN is defined.
module am_rr_arbiter
  import am_query_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned TAG_WIDTH = ceil_log2(N_REQ)
) (
`ifdef AM_ARB_ROUND_ROBIN_EN
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 update,
`endif
  input  logic [N_REQ-1:0]     req,
  output logic [N_REQ-1:0]     grant,
  output logic [TAG_WIDTH-1:0] grant_idx,
  output logic                 any_req
);

  assign any_req = |req;

`ifdef AM_ARB_ROUND_ROBIN_EN
  logic [TAG_WIDTH-1:0] ptr_q;

  // First pass searches above the pointer, second pass wraps to the lowest index.
  always_comb begin
    logic found;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req[i] && !found && (i > int'(ptr_q))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = TAG_WIDTH'(i);
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req[i] && !found) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = TAG_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= TAG_WIDTH'(N_REQ - 1);
    end else if (update) begin
      ptr_q <= grant_idx;
    end
  end
`else
  always_comb begin
    logic found;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req[i] && !found) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = TAG_WIDTH'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/am_query_arbiter.sv
// Shares one associative memory among N_REQ query producers, one query in flight.
// Define AM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority.
module am_query_arbiter
  import am_query_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned LAT_WIDTH      = 16,
  parameter int unsigned TAG_WIDTH      = ceil_log2(N_REQ),
  parameter int unsigned HV_DIMENSION   = HvDimension,
  parameter int unsigned LABEL_WIDTH    = LabelWidth,
  parameter int unsigned DISTANCE_WIDTH = DistanceWidth
) (
  input  logic                          Clk_CI,
  input  logic                          Reset_RI,
  input  logic [N_REQ-1:0]              ValidIn_SI,
  output logic [N_REQ-1:0]              ReadyOut_SO,
  input  logic [N_REQ*HV_DIMENSION-1:0] HypervectorIn_DI,
  output logic                          AmValidOut_SO,
  input  logic                          AmReadyIn_SI,
  output logic [HV_DIMENSION-1:0]       AmHypervectorOut_DO,
  input  logic                          AmValidIn_SI,
  output logic                          AmReadyOut_SO,
  input  logic [LABEL_WIDTH-1:0]        AmLabel_A_DI,
  input  logic [LABEL_WIDTH-1:0]        AmLabel_V_DI,
  input  logic [DISTANCE_WIDTH-1:0]     AmDistance_A_DI,
  input  logic [DISTANCE_WIDTH-1:0]     AmDistance_V_DI,
  output logic                          ValidOut_SO,
  input  logic                          ReadyIn_SI,
  output logic [TAG_WIDTH-1:0]          TagOut_DO,
  output logic [LABEL_WIDTH-1:0]        LabelOut_A_DO,
  output logic [LABEL_WIDTH-1:0]        LabelOut_V_DO,
  output logic [DISTANCE_WIDTH-1:0]     DistanceOut_A_DO,
  output logic [DISTANCE_WIDTH-1:0]     DistanceOut_V_DO,
  output logic [LAT_WIDTH-1:0]          LatencyOut_DO
);

  am_arb_state_e             state_q;
  logic [HV_DIMENSION-1:0]   query_q;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic [LAT_WIDTH-1:0]      lat_q;
  logic [LAT_WIDTH-1:0]      lat_inc;
  logic [LAT_WIDTH-1:0]      lat_out_q;
  logic [LABEL_WIDTH-1:0]    label_a_q;
  logic [LABEL_WIDTH-1:0]    label_v_q;
  logic [DISTANCE_WIDTH-1:0] dist_a_q;
  logic [DISTANCE_WIDTH-1:0] dist_v_q;
  logic                      am_valid_q;
  logic                      valid_q;

  logic [N_REQ-1:0]          grant;
  logic [TAG_WIDTH-1:0]      grant_idx;
  logic                      any_req;
  logic                      grant_fire;
  logic [HV_DIMENSION-1:0]   sel_hv;

  am_rr_arbiter #(
    .N_REQ     (N_REQ),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_arbiter (
`ifdef AM_ARB_ROUND_ROBIN_EN
    .clk       (Clk_CI),
    .rst       (Reset_RI),
    .update    (grant_fire),
`endif
    .req       (ValidIn_SI),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign grant_fire    = (state_q == AmArbIdle) && any_req;
  assign ReadyOut_SO   = grant_fire ? grant : '0;
  assign AmReadyOut_SO = (state_q == AmArbWaitResult) && AmValidIn_SI;
  assign lat_inc       = (&lat_q) ? lat_q : lat_q + LAT_WIDTH'(1);

  always_comb begin
    sel_hv = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_hv = HypervectorIn_DI[i*HV_DIMENSION +: HV_DIMENSION];
    end
  end

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_q    <= AmArbIdle;
      query_q    <= '0;
      tag_q      <= '0;
      lat_q      <= '0;
      lat_out_q  <= '0;
      label_a_q  <= '0;
      label_v_q  <= '0;
      dist_a_q   <= '0;
      dist_v_q   <= '0;
      am_valid_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        AmArbIdle: begin
          if (any_req) begin
            query_q    <= sel_hv;
            tag_q      <= grant_idx;
            lat_q      <= '0;
            am_valid_q <= 1'b1;
            state_q    <= AmArbIssue;
          end
        end
        AmArbIssue: begin
          lat_q <= lat_inc;
          if (AmReadyIn_SI) begin
            am_valid_q <= 1'b0;
            state_q    <= AmArbWaitResult;
          end
        end
        AmArbWaitResult: begin
          lat_q <= lat_inc;
          if (AmValidIn_SI) begin
            // Capture cycle counts toward latency, hence lat_inc rather than lat_q.
            lat_out_q <= lat_inc;
            label_a_q <= AmLabel_A_DI;
            label_v_q <= AmLabel_V_DI;
            dist_a_q  <= AmDistance_A_DI;
            dist_v_q  <= AmDistance_V_DI;
            valid_q   <= 1'b1;
            state_q   <= AmArbDeliver;
          end
        end
        AmArbDeliver: begin
          if (ReadyIn_SI) begin
            valid_q <= 1'b0;
            state_q <= AmArbIdle;
          end
        end
        default: state_q <= AmArbIdle;
      endcase
    end
  end

  assign AmValidOut_SO       = am_valid_q;
  assign AmHypervectorOut_DO = query_q;
  assign ValidOut_SO         = valid_q;
  assign TagOut_DO           = tag_q;
  assign LabelOut_A_DO       = label_a_q;
  assign LabelOut_V_DO       = label_v_q;
  assign DistanceOut_A_DO    = dist_a_q;
  assign DistanceOut_V_DO    = dist_v_q;
  assign LatencyOut_DO       = lat_out_q;

endmodule

// File: tb/tb_am_query_arbiter.sv
// Randomised self-checking bench for am_query_arbiter with a behavioural AM stub
// and a transaction-level reference model of grants, results and latency.
module tb_am_query_arbiter;
  import am_query_arbiter_pkg::*;

  localparam int unsigned N   = 3;
  localparam int unsigned LW  = 5;
  localparam int unsigned TW  = ceil_log2(N);
  localparam int unsigned HV  = HvDimension;
  localparam int unsigned LBW = LabelWidth;
  localparam int unsigned DSW = DistanceWidth;
  localparam int          LAT_MAX = (1 << LW) - 1;

  logic              Clk_CI = 1'b0;
  logic              Reset_RI;
  logic [N-1:0]      ValidIn_SI;
  logic [N-1:0]      ReadyOut_SO;
  logic [N*HV-1:0]   HypervectorIn_DI;
  logic              AmValidOut_SO;
  logic              AmReadyIn_SI;
  logic [HV-1:0]     AmHypervectorOut_DO;
  logic              AmValidIn_SI;
  logic              AmReadyOut_SO;
  logic [LBW-1:0]    AmLabel_A_DI, AmLabel_V_DI;
  logic [DSW-1:0]    AmDistance_A_DI, AmDistance_V_DI;
  logic              ValidOut_SO;
  logic              ReadyIn_SI;
  logic [TW-1:0]     TagOut_DO;
  logic [LBW-1:0]    LabelOut_A_DO, LabelOut_V_DO;
  logic [DSW-1:0]    DistanceOut_A_DO, DistanceOut_V_DO;
  logic [LW-1:0]     LatencyOut_DO;

  am_query_arbiter #(
    .N_REQ     (N),
    .LAT_WIDTH (LW)
  ) dut (
    .Clk_CI              (Clk_CI),
    .Reset_RI            (Reset_RI),
    .ValidIn_SI          (ValidIn_SI),
    .ReadyOut_SO         (ReadyOut_SO),
    .HypervectorIn_DI    (HypervectorIn_DI),
    .AmValidOut_SO       (AmValidOut_SO),
    .AmReadyIn_SI        (AmReadyIn_SI),
    .AmHypervectorOut_DO (AmHypervectorOut_DO),
    .AmValidIn_SI        (AmValidIn_SI),
    .AmReadyOut_SO       (AmReadyOut_SO),
    .AmLabel_A_DI        (AmLabel_A_DI),
    .AmLabel_V_DI        (AmLabel_V_DI),
    .AmDistance_A_DI     (AmDistance_A_DI),
    .AmDistance_V_DI     (AmDistance_V_DI),
    .ValidOut_SO         (ValidOut_SO),
    .ReadyIn_SI          (ReadyIn_SI),
    .TagOut_DO           (TagOut_DO),
    .LabelOut_A_DO       (LabelOut_A_DO),
    .LabelOut_V_DO       (LabelOut_V_DO),
    .DistanceOut_A_DO    (DistanceOut_A_DO),
    .DistanceOut_V_DO    (DistanceOut_V_DO),
    .LatencyOut_DO       (LatencyOut_DO)
  );

  always #5 Clk_CI = ~Clk_CI;

  int checks = 0;
  int errors = 0;

  logic [N-1:0]  pend;
  logic [HV-1:0] hv [N];
  int            last_g;
  int            seen_tags[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arbitration rule, stated directly from the priority policy.
  function automatic int model_grant(input logic [N-1:0] p, input int last);
`ifdef AM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= int'(N); k++) begin
      if (p[(last + k) % int'(N)]) return (last + k) % int'(N);
    end
`else
    for (int i = 0; i < int'(N); i++) begin
      if (p[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic drive();
    ValidIn_SI = pend;
    for (int i = 0; i < int'(N); i++) HypervectorIn_DI[i*HV +: HV] = hv[i];
  endtask

  task automatic raise(input int i);
    if (!pend[i]) begin
      pend[i] = 1'b1;
      hv[i]   = {$urandom, $urandom};
    end
  endtask

  // One full query: grant, s AM stall cycles, AM result after d wait cycles, bp result stalls.
  task automatic run_query(input int s, input int d, input int bp, input bit add_req,
                           input logic [LBW-1:0] la, input logic [LBW-1:0] lv,
                           input logic [DSW-1:0] da, input logic [DSW-1:0] dv);
    int g;
    int exp_lat;
    logic [HV-1:0] qhv;
    @(negedge Clk_CI);
    g = model_grant(pend, last_g);
    check("grant", 64'(ReadyOut_SO), 64'(onehot(g)));
    if (g < 0) return;
    qhv = hv[g];
    @(posedge Clk_CI); #1;
    pend[g] = 1'b0;
    last_g  = g;
    if (add_req) raise($urandom_range(0, N - 1));
    drive();
    for (int k = 0; k <= s; k++) begin
      AmReadyIn_SI = (k == s);
      @(negedge Clk_CI);
      check("am_valid_issue", 64'(AmValidOut_SO), 64'd1);
      check("am_query", AmHypervectorOut_DO, qhv);
      check("ready_busy", 64'(ReadyOut_SO), 64'd0);
      @(posedge Clk_CI); #1;
    end
    AmReadyIn_SI = 1'b0;
    for (int k = 1; k <= d; k++) begin
      if (k == d) begin
        AmValidIn_SI    = 1'b1;
        AmLabel_A_DI    = la;
        AmLabel_V_DI    = lv;
        AmDistance_A_DI = da;
        AmDistance_V_DI = dv;
      end
      @(negedge Clk_CI);
      check("am_valid_wait", 64'(AmValidOut_SO), 64'd0);
      check("am_ready_out", 64'(AmReadyOut_SO), 64'(k == d));
      @(posedge Clk_CI); #1;
    end
    AmValidIn_SI    = 1'b0;
    AmLabel_A_DI    = LBW'($urandom);
    AmLabel_V_DI    = LBW'($urandom);
    AmDistance_A_DI = DSW'($urandom);
    AmDistance_V_DI = DSW'($urandom);
    exp_lat = (s + 1 + d > LAT_MAX) ? LAT_MAX : s + 1 + d;
    for (int k = 0; k <= bp; k++) begin
      ReadyIn_SI = (k == bp);
      @(negedge Clk_CI);
      check("valid_out", 64'(ValidOut_SO), 64'd1);
      check("tag", 64'(TagOut_DO), 64'(g));
      check("label_a", 64'(LabelOut_A_DO), 64'(la));
      check("label_v", 64'(LabelOut_V_DO), 64'(lv));
      check("dist_a", 64'(DistanceOut_A_DO), 64'(da));
      check("dist_v", 64'(DistanceOut_V_DO), 64'(dv));
      check("latency", 64'(LatencyOut_DO), 64'(exp_lat));
      check("ready_deliver", 64'(ReadyOut_SO), 64'd0);
      if (k == bp) seen_tags.push_back(int'(TagOut_DO));
      @(posedge Clk_CI); #1;
    end
    ReadyIn_SI = 1'b0;
  endtask

  task automatic run_random(input int s, input int d, input int bp, input bit add_req);
    run_query(s, d, bp, add_req, LBW'($urandom), LBW'($urandom), DSW'($urandom),
              DSW'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(ReadyOut_SO), 64'd0);
    check({tag, "_am_valid"}, 64'(AmValidOut_SO), 64'd0);
    check({tag, "_am_ready"}, 64'(AmReadyOut_SO), 64'd0);
    check({tag, "_valid"}, 64'(ValidOut_SO), 64'd0);
    check({tag, "_tag"}, 64'(TagOut_DO), 64'd0);
    check({tag, "_labels"}, 64'({LabelOut_A_DO, LabelOut_V_DO}), 64'd0);
    check({tag, "_dists"}, 64'({DistanceOut_A_DO, DistanceOut_V_DO}), 64'd0);
    check({tag, "_lat"}, 64'(LatencyOut_DO), 64'd0);
    check({tag, "_am_hv"}, AmHypervectorOut_DO, 64'd0);
  endtask

  int exp_order[3];

  initial begin
    Reset_RI        = 1'b1;
    pend            = '0;
    for (int i = 0; i < int'(N); i++) hv[i] = '0;
    last_g          = N - 1;
    AmReadyIn_SI    = 1'b0;
    AmValidIn_SI    = 1'b0;
    AmLabel_A_DI    = '0;
    AmLabel_V_DI    = '0;
    AmDistance_A_DI = '0;
    AmDistance_V_DI = '0;
    ReadyIn_SI      = 1'b0;
    drive();
    repeat (2) @(posedge Clk_CI);
    #1;
    check_all_zero("reset");
    Reset_RI = 1'b0;

    // All requesters held valid for three queries.
`ifdef AM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2};
`else
    exp_order = '{0, 0, 0};
`endif
    seen_tags.delete();
    for (int q = 0; q < 3; q++) begin
      for (int i = 0; i < int'(N); i++) raise(i);
      drive();
      run_random(0, 2, 0, 1'b0);
    end
    for (int q = 0; q < 3; q++) check("grant_order", 64'(seen_tags[q]), 64'(exp_order[q]));
    for (int q = 0; q < int'(N) && pend != '0; q++) run_random(0, 1, 0, 1'b0);

    // Single request from requester 1 with a 20-cycle AM.
    pend[1] = 1'b1;
    hv[1]   = {32'hA5A5A5A5, 32'hA5A5A5A5};
    drive();
    run_query(0, 20, 0, 1'b0, LBW'(1), LBW'(0), DSW'(12), DSW'(40));

    // Result backpressure with a request arriving while busy.
    raise(2);
    drive();
    run_random(0, 3, 10, 1'b1);
    // AM stalls for 5 cycles before accepting.
    run_random(5, 4, 0, 1'b0);
    // Latency counter saturation.
    if (pend == '0) begin raise(0); drive(); end
    run_random(0, 40, 0, 1'b0);

    // Randomised traffic.
    for (int q = 0; q < 20; q++) begin
      if (pend == '0) begin
        @(negedge Clk_CI);
        check("idle_ready", 64'(ReadyOut_SO), 64'd0);
        @(posedge Clk_CI); #1;
        raise($urandom_range(0, N - 1));
        if ($urandom_range(0, 1) == 1) raise($urandom_range(0, N - 1));
        drive();
      end
      run_random($urandom_range(0, 3), $urandom_range(1, 10), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
    end

    // Reset while waiting for the AM result.
    while (pend != '0) run_random(0, 1, 0, 1'b0);
    raise(2);
    drive();
    @(posedge Clk_CI); #1;
    pend = '0;
    drive();
    AmReadyIn_SI = 1'b1;
    @(posedge Clk_CI); #1;
    AmReadyIn_SI = 1'b0;
    @(posedge Clk_CI); #1;
    Reset_RI = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge Clk_CI); #1;
    Reset_RI = 1'b0;
    last_g   = N - 1;
    raise(1);
    drive();
    run_random(1, 3, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
